// File: rtl/p12_pkg.sv
// Shared definitions for the p12 scan-chain host: state encoding, byte width
// and byte-count helper.
package p12_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_EMIT,
        S_DONE
    } state_t;

    function automatic int ceil_bytes(input int len);
        return (len + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/p12_scan_serdes.sv
// Per-byte serialiser/deserialiser: tx shift register, rx capture register
// and the count of bits shifted in the current byte.
module p12_scan_serdes
    import p12_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [BYTE_W-1:0] din,
    input  logic [3:0]        nbits,
    input  logic              sin,
    output logic              sout,
    output logic              last,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] tx;
    logic [BYTE_W-1:0] rx;
    logic [3:0]        bcnt;
    logic [3:0]        nb;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx   <= '0;
            rx   <= '0;
            bcnt <= '0;
            nb   <= '0;
        end else if (load) begin
            tx   <= din;
            rx   <= '0;
            bcnt <= '0;
            nb   <= nbits;
        end else if (shift) begin
            tx   <= tx >> 1;
            rx   <= {sin, rx[BYTE_W-1:1]};
            bcnt <= bcnt + 4'd1;
        end
    end

    assign sout = tx[0];
    assign last = (bcnt == nb - 4'd1);
    // Captured bits enter at the MSB; a short byte is pulled down to bit 0.
    assign rdata = rx >> (4'(BYTE_W) - nb);

endmodule

// File: rtl/p12_scan_host.sv
// Scan-chain initiator: streams CHAIN_LEN config bits into the grid and
// returns the bits shifted out as a readback byte stream.
module p12_scan_host
    import p12_pkg::*;
#(
    parameter int CHAIN_LEN = 576,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              scan_se,
    output logic              scan_out,
    input  logic              scan_in
);

    localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  rem;
    logic [3:0]        nbits;
    logic              load, shift, last, sout;
    logic [BYTE_W-1:0] rx_data;

    // Bits still owed to the chain decide how many of this byte get shifted.
    assign rem   = LEN - cnt;
    assign nbits = (32'(rem) >= BYTE_W) ? 4'(BYTE_W) : 4'(rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start)
                cnt <= '0;
            else if (shift)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        wr_ready = 1'b0;
        rd_valid = 1'b0;
        scan_se  = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                busy     = 1'b1;
                wr_ready = 1'b1;
                if (wr_valid) begin
                    load     = 1'b1;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy    = 1'b1;
                scan_se = 1'b1;
                shift   = 1'b1;
                if (last) state_nx = S_EMIT;
            end
            S_EMIT: begin
                busy     = 1'b1;
                rd_valid = 1'b1;
                if (rd_ready) state_nx = (cnt == LEN) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    p12_scan_serdes u_serdes (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (wr_data),
        .nbits (nbits),
        .sin   (scan_in),
        .sout  (sout),
        .last  (last),
        .rdata (rx_data)
    );

    assign scan_out = scan_se & sout;
    assign rd_data  = rd_valid ? rx_data : '0;

endmodule

// File: tb/tb_p12_scan_host.sv
// Bench for p12_scan_host: two instances (16- and 12-flop chains), each
// attached to a behavioural shift-register model of the grid.
module tb_p12_scan_host;
    import p12_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, wr_valid, rd_ready, sel, pre_load;
    logic [7:0] wr_data;
    logic [15:0] pre_val;

    logic busy_a, done_a, wrr_a, rdv_a, se_a, so_a;
    logic busy_b, done_b, wrr_b, rdv_b, se_b, so_b;
    logic [7:0] rdd_a, rdd_b;
    logic [15:0] ga;
    logic [11:0] gb;

    // Grid models: chain end is bit 0, new bits enter at the top.
    always @(posedge clk) begin
        if (pre_load) begin
            ga <= pre_val;
            gb <= pre_val[11:0];
        end else begin
            if (se_a) ga <= {so_a, ga[15:1]};
            if (se_b) gb <= {so_b, gb[11:1]};
        end
    end

    p12_scan_host #(.CHAIN_LEN(16), .CNT_W(5)) u_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .busy(busy_a), .done(done_a),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wrr_a),
        .rd_data(rdd_a), .rd_valid(rdv_a), .rd_ready(rd_ready),
        .scan_se(se_a), .scan_out(so_a), .scan_in(ga[0]));

    p12_scan_host #(.CHAIN_LEN(12), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start & sel), .busy(busy_b), .done(done_b),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wrr_b),
        .rd_data(rdd_b), .rd_valid(rdv_b), .rd_ready(rd_ready),
        .scan_se(se_b), .scan_out(so_b), .scan_in(gb[0]));

    logic busy, done, wr_ready, rd_valid, scan_se, scan_out;
    logic [7:0] rd_data;
    assign busy     = sel ? busy_b : busy_a;
    assign done     = sel ? done_b : done_a;
    assign wr_ready = sel ? wrr_b  : wrr_a;
    assign rd_valid = sel ? rdv_b  : rdv_a;
    assign scan_se  = sel ? se_b   : se_a;
    assign scan_out = sel ? so_b   : so_a;
    assign rd_data  = sel ? rdd_b  : rdd_a;

    int n_cmp = 0;
    int n_err = 0;

    task automatic preload(input logic [15:0] v);
        @(negedge clk);
        pre_load = 1'b1;
        pre_val  = v;
        @(negedge clk);
        pre_load = 1'b0;
    endtask

    // One complete transaction checked against the grid model's rules:
    // readback = previous chain contents, new contents = bits written.
    task automatic txn(input bit s, input logic [15:0] pre, input logic [15:0] dat,
                       input int rd_hold, input int wr_delay, input bit spur);
        int n, nb, bits, cyc, wi, ri, se_n, run, hold, wdel;
        bit got_done;
        logic [7:0]  exp_rd [2];
        logic [15:0] exp_g, got_g;
        n  = s ? 12 : 16;
        nb = ceil_bytes(n);
        for (int i = 0; i < nb; i++) begin
            bits = (n - 8*i > 8) ? 8 : n - 8*i;
            exp_rd[i] = 8'((pre >> (8*i)) & ((16'd1 << bits) - 16'd1));
        end
        exp_g = dat & 16'((32'd1 << n) - 1);
        preload(pre);
        sel = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL busy_after_start got=%b want=1", busy);
        end
        cyc = 0; wi = 0; ri = 0; se_n = 0; run = 0;
        hold = rd_hold; wdel = wr_delay; got_done = 0;
        while (!got_done && cyc < 300) begin
            start = 1'b0;
            if (scan_se) begin
                se_n++; run++;
                if (spur && se_n == 3) start = 1'b1;
            end else begin
                run = 0;
            end
            n_cmp++;
            if (run > 8 || (scan_se && (rd_valid || wr_ready)) || (rd_valid && wr_ready)) begin
                n_err++;
                $display("FAIL se_guard run=%0d se=%b rd_valid=%b wr_ready=%b", run, scan_se, rd_valid, wr_ready);
            end
            if (done) begin
                got_done = 1;
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_err++; $display("FAIL busy_in_done got=%b want=0", busy);
                end
                if (spur) start = 1'b1;
            end
            if (wr_ready && wi >= nb) begin
                n_cmp++; n_err++;
                $display("FAIL extra_wr wr_ready=1 after %0d bytes, want 0", wi);
            end
            if (wr_ready && wi < nb && wdel == 0 && $urandom_range(0, 3) != 0) begin
                wr_valid = 1'b1;
                wr_data  = dat[8*wi +: 8];
                wi++;
            end else begin
                if (wr_ready && wdel > 0) begin
                    wdel--;
                    n_cmp++;
                    if (busy !== 1'b1) begin
                        n_err++; $display("FAIL busy_in_stall got=%b want=1", busy);
                    end
                end
                wr_valid = (wi == nb) ? 1'($urandom_range(0, 1)) : 1'b0;
                wr_data  = 8'($urandom);
            end
            if (rd_valid) begin
                n_cmp++;
                if (ri >= nb) begin
                    n_err++; $display("FAIL extra_rd byte %0d, want only %0d", ri, nb);
                end else if (rd_data !== exp_rd[ri]) begin
                    n_err++; $display("FAIL rd_data[%0d] got=%h want=%h", ri, rd_data, exp_rd[ri]);
                end
                if (hold > 0) begin
                    hold--; rd_ready = 1'b0;
                end else if ($urandom_range(0, 2) != 0) begin
                    rd_ready = 1'b1; ri++;
                end else begin
                    rd_ready = 1'b0;
                end
            end else begin
                rd_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        n_cmp++;
        if (!got_done) begin
            n_err++; $display("FAIL timeout no done within %0d cycles", cyc);
        end
        got_g = s ? {4'b0, gb} : ga;
        n_cmp++;
        if (ri !== nb || wi !== nb) begin
            n_err++; $display("FAIL byte_count rd=%0d wr=%0d want=%0d", ri, wi, nb);
        end
        n_cmp++;
        if (se_n !== n) begin
            n_err++; $display("FAIL se_cycles got=%0d want=%0d", se_n, n);
        end
        n_cmp++;
        if (got_g !== exp_g) begin
            n_err++; $display("FAIL grid_contents got=%h want=%h", got_g, exp_g);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b0) begin
                n_err++; $display("FAIL post_idle busy=%b done=%b wr_ready=%b want 0 0 0", busy, done, wr_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_cmp++;
            if ({busy, done, wr_ready, rd_valid, scan_se, scan_out, rd_data} !== 14'd0) begin
                n_err++;
                $display("FAIL %s dut%0d busy=%b done=%b wr_ready=%b rd_valid=%b se=%b so=%b rd_data=%h want all 0",
                         tag, s, busy, done, wr_ready, rd_valid, scan_se, scan_out, rd_data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        wr_data = 8'h00; sel = 1'b0; pre_load = 1'b1; pre_val = 16'h0;
        repeat (3) @(negedge clk);
        pre_load = 1'b0;
        check_reset_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_trip();
        txn(1'b0, 16'hBEEF, 16'h1234, 0, 0, 1'b0);
    endtask

    task automatic test_partial_byte();
        txn(1'b1, 16'h0ABC, 16'hF765, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        txn(1'b0, 16'($urandom), 16'($urandom), 20, 0, 1'b0);
    endtask

    task automatic test_wr_stall();
        txn(1'b1, 16'($urandom), 16'($urandom), 0, 5, 1'b0);
    endtask

    task automatic test_spurious_start();
        txn(1'b0, 16'($urandom), 16'($urandom), 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_shift();
        int se_n, cyc;
        preload(16'h5A5A);
        sel = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        se_n = 0; cyc = 0;
        while (se_n < 3 && cyc < 50) begin
            wr_valid = wr_ready;
            wr_data  = 8'hC3;
            if (scan_se) se_n++;
            if (se_n == 3) rst = 1'b1;
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        n_cmp++;
        if (se_n != 3) begin
            n_err++; $display("FAIL reset_mid_timeout se seen=%0d want=3", se_n);
        end
        check_reset_outputs("reset_mid_shift");
        sel = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL after_abort done=%b busy=%b want 0 0", done, busy);
            end
        end
        txn(1'b0, 16'h0F0F, 16'($urandom), 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++)
            txn(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_partial_byte();
        test_backpressure();
        test_wr_stall();
        test_spurious_start();
        test_reset_mid_shift();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
